// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the 2-input gate response checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Expected output indexed by {A,B}; bit0 is A=0,B=0.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_response_checker_if.sv
// Stimulus/observation and verdict bundle between a gate bench driver and the checker.
interface gate_response_checker_if #(
  parameter int unsigned CNT_W = 8
);

  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             vld;
  logic             a;
  logic             b;
  logic             o;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_err_idx;
  logic [2:0]       first_err_vec;
  logic [3:0]       cov;

  modport master (
    output start, num_vec, vld, a, b, o,
    input  busy, done, pass, err_cnt, first_err_idx, first_err_vec, cov
  );

  modport slave (
    input  start, num_vec, vld, a, b, o,
    output busy, done, pass, err_cnt, first_err_idx, first_err_vec, cov
  );

endinterface

// File: rtl/gate_chk_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module gate_chk_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gate_response_checker.sv
// Compares a 2-input gate's sampled output against a truth table over a run of vectors,
// tracking coverage and the first failure, and registers a pass/fail verdict.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE = TT_NAND,
  parameter int unsigned CNT_W       = 8
) (
  input logic              clk,
  input logic              rst_n,
  gate_response_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [3:0]       cov_q, cov_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [2:0]       fe_vec_q, fe_vec_d;
  logic             fe_seen_q, fe_seen_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] err_cnt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             exp_o;
  logic             mism;

  gate_chk_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (err_cnt)
  );

  assign exp_o = TRUTH_TABLE[{bus.a, bus.b}];
  assign mism  = (bus.o != exp_o);

  // Next-state and result updates; start only acts outside RUN and beats a coincident vld.
  always_comb begin
    state_d   = state_q;
    num_vec_d = num_vec_q;
    vec_cnt_d = vec_cnt_q;
    cov_d     = cov_q;
    fe_idx_d  = fe_idx_q;
    fe_vec_d  = fe_vec_q;
    fe_seen_d = fe_seen_q;
    pass_d    = pass_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          cnt_clr   = 1'b1;
          vec_cnt_d = '0;
          cov_d     = '0;
          fe_idx_d  = '0;
          fe_vec_d  = '0;
          fe_seen_d = 1'b0;
          pass_d    = 1'b0;
          num_vec_d = bus.num_vec;
          state_d   = (bus.num_vec != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (bus.vld) begin
          cov_d[{bus.a, bus.b}] = 1'b1;
          vec_cnt_d = vec_cnt_q + ONE;
          if (mism) begin
            cnt_inc = 1'b1;
            if (!fe_seen_q) begin
              fe_idx_d  = vec_cnt_q;
              fe_vec_d  = {bus.a, bus.b, bus.o};
              fe_seen_d = 1'b1;
            end
          end
          // Verdict uses the post-update error state, so a mismatch on the last vector fails.
          if (vec_cnt_q == (num_vec_q - ONE)) begin
            state_d = ST_DONE;
            pass_d  = (err_cnt == '0) && !mism && (cov_d == 4'b1111);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      num_vec_q <= '0;
      vec_cnt_q <= '0;
      cov_q     <= '0;
      fe_idx_q  <= '0;
      fe_vec_q  <= '0;
      fe_seen_q <= 1'b0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_vec_q <= num_vec_d;
      vec_cnt_q <= vec_cnt_d;
      cov_q     <= cov_d;
      fe_idx_q  <= fe_idx_d;
      fe_vec_q  <= fe_vec_d;
      fe_seen_q <= fe_seen_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err_idx = fe_idx_q;
  assign bus.first_err_vec = fe_vec_q;
  assign bus.cov           = cov_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: NAND table, 8-bit and 2-bit counter instances.
module tb_gate_response_checker;
  import gate_chk_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  gate_response_checker_if #(.CNT_W(8)) g8 ();
  gate_response_checker_if #(.CNT_W(2)) g2 ();

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .CNT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (g8.slave)
  );

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (g2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on the 8-bit instance; outputs sampled 1ns after the edge.
  task automatic drv8(input logic st, input logic [7:0] nv, input logic v,
                      input logic ia, input logic ib, input logic io);
    @(negedge clk);
    g8.start = st; g8.num_vec = nv; g8.vld = v; g8.a = ia; g8.b = ib; g8.o = io;
    @(posedge clk);
    #1;
    g8.start = 1'b0; g8.vld = 1'b0;
  endtask

  task automatic drv2(input logic st, input logic [1:0] nv, input logic v,
                      input logic ia, input logic ib, input logic io);
    @(negedge clk);
    g2.start = st; g2.num_vec = nv; g2.vld = v; g2.a = ia; g2.b = ib; g2.o = io;
    @(posedge clk);
    #1;
    g2.start = 1'b0; g2.vld = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    g8.start = 1'b0; g8.num_vec = '0; g8.vld = 1'b0; g8.a = 1'b0; g8.b = 1'b0; g8.o = 1'b0;
    g2.start = 1'b0; g2.num_vec = '0; g2.vld = 1'b0; g2.a = 1'b0; g2.b = 1'b0; g2.o = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_busy", 32'(g8.busy), 0);
    chk("rst_done", 32'(g8.done), 0);
    chk("rst_pass", 32'(g8.pass), 0);
    chk("rst_err",  32'(g8.err_cnt), 0);
    chk("rst_cov",  32'(g8.cov), 0);

    // 1: ideal NAND over all four combinations
    drv8(1, 8'd4, 0, 0, 0, 0);
    chk("t1_busy", 32'(g8.busy), 1);
    drv8(0, 8'd0, 1, 0, 0, 1);
    drv8(0, 8'd0, 1, 0, 1, 1);
    drv8(0, 8'd0, 1, 1, 0, 1);
    chk("t1_not_done_yet", 32'(g8.done), 0);
    drv8(0, 8'd0, 1, 1, 1, 0);
    chk("t1_done", 32'(g8.done), 1);
    chk("t1_busy_lo", 32'(g8.busy), 0);
    chk("t1_pass", 32'(g8.pass), 1);
    chk("t1_err", 32'(g8.err_cnt), 0);
    chk("t1_cov", 32'(g8.cov), 32'hF);

    // 2: output stuck at 1; only {1,1} mismatches
    drv8(1, 8'd4, 0, 0, 0, 0);
    chk("t2_clr_done", 32'(g8.done), 0);
    chk("t2_clr_cov", 32'(g8.cov), 0);
    drv8(0, 8'd0, 1, 0, 0, 1);
    drv8(0, 8'd0, 1, 0, 1, 1);
    drv8(0, 8'd0, 1, 1, 0, 1);
    drv8(0, 8'd0, 1, 1, 1, 1);
    chk("t2_done", 32'(g8.done), 1);
    chk("t2_err", 32'(g8.err_cnt), 1);
    chk("t2_fe_idx", 32'(g8.first_err_idx), 3);
    chk("t2_fe_vec", 32'(g8.first_err_vec), 32'b111);
    chk("t2_pass", 32'(g8.pass), 0);

    // 3: correct outputs but incomplete coverage
    drv8(1, 8'd3, 0, 0, 0, 0);
    chk("t3_fe_vec_clr", 32'(g8.first_err_vec), 0);
    drv8(0, 8'd0, 1, 0, 0, 1);
    drv8(0, 8'd0, 1, 0, 1, 1);
    drv8(0, 8'd0, 1, 0, 1, 1);
    chk("t3_done", 32'(g8.done), 1);
    chk("t3_err", 32'(g8.err_cnt), 0);
    chk("t3_cov", 32'(g8.cov), 32'b0011);
    chk("t3_pass", 32'(g8.pass), 0);

    // 4: reset mid-run, then a clean run
    drv8(1, 8'd4, 0, 0, 0, 0);
    drv8(0, 8'd0, 1, 0, 0, 0);
    drv8(0, 8'd0, 1, 0, 1, 1);
    chk("t4_pre_err", 32'(g8.err_cnt), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(g8.busy), 0);
    chk("t4_rst_done", 32'(g8.done), 0);
    chk("t4_rst_err", 32'(g8.err_cnt), 0);
    chk("t4_rst_cov", 32'(g8.cov), 0);
    chk("t4_rst_fe_idx", 32'(g8.first_err_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv8(1, 8'd4, 0, 0, 0, 0);
    drv8(0, 8'd0, 1, 1, 1, 0);
    drv8(0, 8'd0, 1, 1, 0, 1);
    drv8(0, 8'd0, 1, 0, 1, 1);
    drv8(0, 8'd0, 1, 0, 0, 1);
    chk("t4_done", 32'(g8.done), 1);
    chk("t4_pass", 32'(g8.pass), 1);
    chk("t4_err", 32'(g8.err_cnt), 0);

    // 6: vld gaps and start pulses during RUN
    drv8(1, 8'd4, 0, 0, 0, 0);
    drv8(0, 8'd0, 1, 0, 0, 1);
    drv8(0, 8'd0, 0, 1, 1, 1);
    drv8(1, 8'd1, 0, 0, 0, 0);
    chk("t6_start_ign", 32'(g8.busy), 1);
    drv8(0, 8'd0, 1, 0, 1, 0);
    drv8(1, 8'd1, 1, 1, 0, 1);
    chk("t6_busy", 32'(g8.busy), 1);
    chk("t6_err_mid", 32'(g8.err_cnt), 1);
    drv8(0, 8'd0, 0, 0, 0, 0);
    drv8(0, 8'd0, 1, 1, 1, 0);
    chk("t6_done", 32'(g8.done), 1);
    chk("t6_err", 32'(g8.err_cnt), 1);
    chk("t6_fe_idx", 32'(g8.first_err_idx), 1);
    chk("t6_fe_vec", 32'(g8.first_err_vec), 32'b010);
    chk("t6_cov", 32'(g8.cov), 32'hF);
    chk("t6_pass", 32'(g8.pass), 0);
    drv8(0, 8'd0, 1, 0, 0, 0);
    chk("t6_done_frozen_err", 32'(g8.err_cnt), 1);
    chk("t6_done_frozen_cov", 32'(g8.cov), 32'hF);
    // start and vld together in DONE: the vld is not counted
    drv8(1, 8'd1, 1, 0, 0, 0);
    chk("t6_sv_busy", 32'(g8.busy), 1);
    chk("t6_sv_err", 32'(g8.err_cnt), 0);
    chk("t6_sv_cov", 32'(g8.cov), 0);
    drv8(0, 8'd0, 1, 0, 0, 1);
    chk("t6_sv_done", 32'(g8.done), 1);
    chk("t6_sv_err2", 32'(g8.err_cnt), 0);
    chk("t6_sv_cov2", 32'(g8.cov), 32'b0001);

    // 5: 2-bit counters, every output inverted
    drv2(1, 2'd3, 0, 0, 0, 0);
    drv2(0, 2'd0, 1, 0, 0, 0);
    drv2(0, 2'd0, 1, 0, 1, 0);
    drv2(0, 2'd0, 1, 1, 0, 0);
    chk("t5_done", 32'(g2.done), 1);
    chk("t5_err_sat", 32'(g2.err_cnt), 3);
    chk("t5_fe_idx", 32'(g2.first_err_idx), 0);
    chk("t5_fe_vec", 32'(g2.first_err_vec), 32'b000);
    chk("t5_pass", 32'(g2.pass), 0);
    drv2(1, 2'd3, 0, 0, 0, 0);
    chk("t5_restart_err", 32'(g2.err_cnt), 0);
    chk("t5_restart_busy", 32'(g2.busy), 1);
    drv2(0, 2'd0, 1, 0, 0, 1);
    drv2(0, 2'd0, 1, 0, 1, 1);
    drv2(0, 2'd0, 1, 1, 1, 0);
    chk("t5_run2_done", 32'(g2.done), 1);
    chk("t5_run2_err", 32'(g2.err_cnt), 0);
    chk("t5_run2_cov", 32'(g2.cov), 32'b1011);
    drv2(1, 2'd0, 0, 0, 0, 0);
    chk("t5_nv0_done", 32'(g2.done), 1);
    chk("t5_nv0_busy", 32'(g2.busy), 0);
    chk("t5_nv0_pass", 32'(g2.pass), 0);
    chk("t5_nv0_cov", 32'(g2.cov), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
